// File: rtl/instr_fetcher.sv
// Instruction fetch front end: one-outstanding icache request FSM feeding a
// circular instruction queue, with JAL-aware next-PC and ROB flush redirect.
module instr_fetcher #(
    parameter int          IQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    output logic        ic_req_valid,
    output logic [31:0] ic_req_addr,
    input  logic        ic_resp_valid,
    input  logic [31:0] ic_resp_instr,
    output logic        iq_out_valid,
    output logic [31:0] iq_out_instr,
    output logic [31:0] iq_out_pc,
    input  logic        iq_out_ready,
    input  logic        flush,
    input  logic [31:0] flush_pc
);
    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(IQ_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    // JAL jumps by its J-immediate; everything else falls through by one word.
    function automatic logic [31:0] next_pc(input logic [31:0]  addr,
                                            input logic [31:12] imm_bits,
                                            input logic [6:0]   opcode);
        logic [31:0] jal_off;
        jal_off = {{12{imm_bits[31]}}, imm_bits[19:12], imm_bits[20], imm_bits[30:21], 1'b0};
        return (opcode == 7'b1101111) ? addr + jal_off : addr + 32'd4;
    endfunction

    fetch_state_t     state;
    logic [31:0]      pc;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [31:0]      iq_instr [IQ_DEPTH];
    logic [31:0]      iq_pc    [IQ_DEPTH];

    logic push;
    logic pop;

    assign pop  = rdy && !flush && (count != '0) && iq_out_ready;
    assign push = rdy && !flush && (state == WAIT) && ic_resp_valid;

    assign iq_out_valid = (count != '0);
    assign iq_out_instr = (count != '0) ? iq_instr[head] : '0;
    assign iq_out_pc    = (count != '0) ? iq_pc[head]    : '0;

    // Queue payload carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            iq_instr[tail] <= ic_resp_instr;
            iq_pc[tail]    <= ic_req_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            ic_req_valid <= 1'b0;
            ic_req_addr  <= '0;
        end else if (rdy) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                pc    <= flush_pc;
                // An unanswered request must have its response swallowed later.
                if (state == IDLE || ic_resp_valid) begin
                    state        <= IDLE;
                    ic_req_valid <= 1'b0;
                end else begin
                    state        <= DROP;
                    ic_req_valid <= 1'b1;
                end
            end else begin
                if (pop)
                    head <= head + PTR_W'(1);
                if (push)
                    tail <= tail + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase

                case (state)
                    IDLE: begin
                        if (count < FULL_CNT) begin
                            ic_req_addr  <= pc;
                            ic_req_valid <= 1'b1;
                            state        <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (ic_resp_valid) begin
                            pc           <= next_pc(ic_req_addr, ic_resp_instr[31:12],
                                                    ic_resp_instr[6:0]);
                            ic_req_valid <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                    DROP: begin
                        if (ic_resp_valid) begin
                            ic_req_valid <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                    default: begin
                        ic_req_valid <= 1'b0;
                        state        <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
